// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage resolves one SLICE of the sum and forwards its carry and the remaining operand bits.

module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  localparam int NG = W / 4;

  logic [NG:0] c;
  assign c[0] = cin;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [3:0] g, p, x, cc;
    logic       gg, gp;
    assign g  = a[4*j +: 4] & b[4*j +: 4];
    assign p  = a[4*j +: 4] | b[4*j +: 4];
    assign x  = a[4*j +: 4] ^ b[4*j +: 4];
    assign cc = {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[j]),
                 g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[j]),
                 g[0] | (p[0] & c[j]),
                 c[j]};
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;
    assign c[j+1]      = gg | (gp & c[j]);
    assign s[4*j +: 4] = x ^ cc;
  end

  assign cout = c[NG];
endmodule

module cla_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int MSB   = WIDTH - 1;

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0]            c_q, c_d;
  logic                         zero_q, zero_d;

  logic [STAGES:0]  vin, adv;
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];
  logic [SLICE-1:0] sl_s  [STAGES];
  logic             sl_co [STAGES];

  // vin[k] is the valid feeding stage k; adv[STAGES] is the drain out of the last stage
  assign vin = {vld_q, in_valid};

  always_comb begin
    adv         = '0;
    adv[STAGES] = vld_q[STAGES-1] & out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      adv[k] = vin[k] & (~vld_q[k] | adv[k+1]);
  end

  assign in_ready = ~vld_q[0] | adv[1];

  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = cin ^ sub;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.W(SLICE)) u_slice (
      .a    (src_a[k][k*SLICE +: SLICE]),
      .b    (src_b[k][k*SLICE +: SLICE]),
      .cin  (src_c[k]),
      .s    (sl_s[k]),
      .cout (sl_co[k])
    );
  end

  always_comb begin
    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    c_d    = c_q;
    zero_d = zero_q;
    for (int k = 0; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k]                 = 1'b1;
        a_d[k]                   = src_a[k];
        b_d[k]                   = src_b[k];
        s_d[k]                   = src_s[k];
        s_d[k][k*SLICE +: SLICE] = sl_s[k];
        c_d[k]                   = sl_co[k];
      end else if (adv[k+1]) begin
        vld_d[k] = 1'b0;
      end
    end
    if (adv[STAGES-1]) zero_d = ~|s_d[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      c_q    <= c_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  // b_q already holds the conditioned operand, so this is the subtract-aware overflow rule
  assign overflow  = (a_q[STAGES-1][MSB] == b_q[STAGES-1][MSB]) &&
                     (s_q[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: 16-bit instances at 1/2/4 stages plus a 32-bit 4-stage streaming instance.
module tb_cla_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] a16, b16;
  logic        cin, sub;
  logic [2:0]  iv, ordy, irdy, ov, co, of, zr;
  logic [15:0] sm [3];

  logic [31:0] a32, b32, sm32;
  logic        cin32, sub32, iv32, ordy32, irdy32, ov32, co32, of32, zr32;

  localparam int ST [3] = '{1, 2, 4};

  cla_pipe #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .cout(co[0]), .overflow(of[0]), .zero(zr[0]));
  cla_pipe #(.WIDTH(16), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .cout(co[1]), .overflow(of[1]), .zero(zr[1]));
  cla_pipe #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a16), .b(b16),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .cout(co[2]), .overflow(of[2]), .zero(zr[2]));
  cla_pipe #(.WIDTH(32), .STAGES(4)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(irdy32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(ordy32), .sum(sm32),
    .cout(co32), .overflow(of32), .zero(zr32));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } res_t;

  function automatic res_t ref_op(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb, input int w);
    logic [31:0] mask, ye;
    logic [32:0] full;
    res_t r;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    ye     = (sb ? ~y : y) & mask;
    full   = {1'b0, x & mask} + {1'b0, ye} + {32'h0, ci ^ sb};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.zero = (r.sum == 32'h0);
    r.ovf  = (x[w-1] == ye[w-1]) && (r.sum[w-1] != x[w-1]);
    return r;
  endfunction

  // scoreboards for the 2-stage 16-bit and the 32-bit instance
  res_t q2[$];
  res_t q32[$];
  int   n2 = 0, n32 = 0, nacc32 = 0, cyc = 0, acc0 = 0, res0 = 0, resl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
      q32.delete();
    end else begin
      if (ov[1] && ordy[1]) begin
        n2++;
        if (q2.size() == 0) chk("u2 unexpected result", 32'(ov[1]), 32'h0);
        else begin
          res_t e;
          e = q2.pop_front();
          chk("u2 stream sum", {16'h0, sm[1]}, e.sum);
          chk("u2 stream flags", {co[1], of[1], zr[1]}, {e.cout, e.ovf, e.zero});
        end
      end
      if (iv[1] && irdy[1]) q2.push_back(ref_op({16'h0, a16}, {16'h0, b16}, cin, sub, 16));
      if (ov32 && ordy32) begin
        n32++;
        if (n32 == 1) res0 = cyc;
        resl = cyc;
        if (q32.size() == 0) chk("u32 unexpected result", 32'(ov32), 32'h0);
        else begin
          res_t e;
          e = q32.pop_front();
          chk("u32 stream sum", sm32, e.sum);
          chk("u32 stream flags", {29'h0, co32, of32, zr32}, {29'h0, e.cout, e.ovf, e.zero});
        end
      end
      if (iv32 && irdy32) begin
        if (nacc32 == 0) acc0 = cyc;
        nacc32++;
        q32.push_back(ref_op(a32, b32, cin32, sub32, 32));
      end
    end
  end

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf, zero;
  } vec_t;

  vec_t        tbl [11];
  logic [15:0] opa [6];
  logic [15:0] opb [6];
  logic        opc [6];
  logic        ops [6];

  initial begin
    res_t e;
    int   fed;
    logic acc;

    tbl[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; iv = '0; ordy = 3'b111; a16 = '0; b16 = '0; cin = 1'b0; sub = 1'b0;
    iv32 = 1'b0; ordy32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      chk("reset out_valid", 32'(ov[j]), 32'h0);
      chk("reset outputs", {13'h0, sm[j], co[j], of[j], zr[j]}, 32'h0);
    end
    chk("reset u32 out", {ov32, co32, of32, zr32}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready after reset", {28'h0, irdy32, irdy}, 32'hF);

    // directed vectors: exact latency and results on every 16-bit depth
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      a16 = tbl[i].a; b16 = tbl[i].b; cin = tbl[i].cin; sub = tbl[i].sub; iv = 3'b111;
      @(negedge clk);
      chk("vec in_ready", 32'(irdy), 32'h7);
      @(posedge clk); #1 iv = '0;
      for (int c = 1; c <= 4; c++) begin
        if (c > 1) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
          chk("vec out_valid timing", 32'(ov[j]), 32'(c == ST[j]));
          if (c == ST[j]) begin
            chk("vec sum", {16'h0, sm[j]}, {16'h0, tbl[i].sum});
            chk("vec cout/ovf/zero", {co[j], of[j], zr[j]},
                {tbl[i].cout, tbl[i].ovf, tbl[i].zero});
          end
        end
      end
    end

    // 32-bit, 4-stage streaming: one result per cycle, in order
    @(posedge clk); #1;
    ordy32 = 1'b1; iv32 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); sub32 = 1'($urandom);
      @(negedge clk);
      chk("u32 in_ready streaming", 32'(irdy32), 32'h1);
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    for (int w = 0; w < 12 && n32 < 100; w++) @(negedge clk);
    chk("u32 result count", n32, 100);
    chk("u32 fill latency", res0 - acc0, 4);
    chk("u32 back-to-back results", resl - res0, 99);

    // 2-stage stall: fill, hold 5 cycles, then toggle out_ready
    for (int k = 0; k < 6; k++) begin
      opa[k] = 16'($urandom); opb[k] = 16'($urandom); opc[k] = 1'($urandom); ops[k] = 1'($urandom);
    end
    n2 = 0;
    ordy = 3'b101;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      a16 = opa[k]; b16 = opb[k]; cin = opc[k]; sub = ops[k]; iv = 3'b010;
      @(negedge clk);
      chk("u2 in_ready while filling", 32'(irdy[1]), 32'h1);
    end
    @(posedge clk); #1;
    a16 = opa[2]; b16 = opb[2]; cin = opc[2]; sub = ops[2];
    e = ref_op({16'h0, opa[0]}, {16'h0, opb[0]}, opc[0], ops[0], 16);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("u2 in_ready when full", 32'(irdy[1]), 32'h0);
      chk("u2 out_valid held", 32'(ov[1]), 32'h1);
      chk("u2 sum stable", {16'h0, sm[1]}, e.sum);
      chk("u2 flags stable", {co[1], of[1], zr[1]}, {e.cout, e.ovf, e.zero});
      @(posedge clk); #1;
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("u2 in_ready on full+drain", 32'(irdy[1]), 32'h1);
    acc = iv[1] & irdy[1];
    fed = 2;
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      if (acc) begin
        fed++;
        if (fed < 6) begin
          a16 = opa[fed]; b16 = opb[fed]; cin = opc[fed]; sub = ops[fed];
        end else iv = '0;
      end
      ordy[1] = t[0];
      @(negedge clk);
      acc = iv[1] & irdy[1];
    end
    @(posedge clk); #1 iv = '0; ordy = 3'b111;
    for (int w = 0; w < 10 && (q2.size() != 0 || ov[1]); w++) @(negedge clk);
    chk("u2 accepted count", fed, 6);
    chk("u2 drained count", n2, 6);

    // reset with two entries in flight
    ordy = 3'b101;
    @(posedge clk); #1; a16 = 16'h1111; b16 = 16'h2222; cin = 1'b0; sub = 1'b0; iv = 3'b010;
    @(posedge clk); #1; a16 = 16'h0F00; b16 = 16'h0100;
    @(posedge clk); #1; iv = '0;
    @(negedge clk);
    chk("u2 full before reset", 32'(ov[1]), 32'h1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("reset in flight out_valid", {29'h0, ov}, 32'h0);
    chk("reset in flight outputs", {13'h0, sm[1], co[1], of[1], zr[1]}, 32'h0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; ordy = 3'b111;
    @(negedge clk);
    chk("post-reset in_ready", 32'(irdy[1]), 32'h1);
    chk("post-reset no result", 32'(ov[1]), 32'h0);
    @(posedge clk); #1; a16 = 16'h4000; b16 = 16'h4000; cin = 1'b0; sub = 1'b0; iv = 3'b010;
    @(posedge clk); #1 iv = '0;
    @(negedge clk);
    chk("post-reset latency early", 32'(ov[1]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("post-reset out_valid", 32'(ov[1]), 32'h1);
    chk("post-reset sum", {16'h0, sm[1]}, 32'h8000);
    chk("post-reset flags", {co[1], of[1], zr[1]}, 3'b010);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the LC4 datapath and its multi-cycle arithmetic units. It generalises the single-cycle 16-bit CLA to any width that is a multiple of 4 and to a configurable number of pipeline stages. It adds a subtract mode and carry, overflow and zero flags. A valid/ready handshake with per-stage stall lets it sit between producer and consumer stages that may back-pressure.

## Interface
- WIDTH, 16: operand width. Must be a multiple of 4 and ≥ 4.
- STAGES, 1: pipeline depth. Must evenly divide WIDTH/4. Each stage resolves SLICE = WIDTH/STAGES bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands are presented.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB.
- overflow  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

## Operation
- Operand conditioning at input: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin. So sub=1, cin=0 yields a−b.
- Per bit: g = a&b_eff, p = a|b_eff. Within each stage, 4-bit lookahead groups produce group G/P and internal carries. Group carries chain within the stage (c4 = G0 | P0&c0, and so on).
- Stage k computes bits [k·SLICE +: SLICE] using the carry registered out of stage k−1. Stage 0 uses c_eff.
- Operand skew: the bits for stage k are carried forward in pipeline registers alongside lower-slice results, so each stage sees its own slice with the correct carry. The registered partial sum accumulates across stages.
- STAGES=1 degenerates to a registered single-stage adder with latency 1.
- overflow = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). It is computed in the final stage.
- cout = carry out of bit WIDTH−1, not inverted in subtract mode. cout=1 means no borrow.
- zero = ~|sum, computed in the final stage and registered with sum.
- Each stage k holds a valid bit v[k]. Stage k advances when v[k−1] is set and (!v[k] or stage k is emptied this cycle).
- Stage STAGES−1 empties when out_valid && out_ready.
- in_ready = !v[0] || advance out of stage 0. This is combinational from downstream readiness. Bubbles collapse.
- A stage that holds and does not advance keeps all of its data bits unchanged.
- out_valid = v[STAGES−1]. sum, cout, overflow and zero come from final-stage registers.

## Timing
- Reset (async assert, any cycle): all v[k]=0, out_valid=0, sum=0, cout=0, overflow=0, zero=0. in_ready=1 in the first cycle after deassertion.
- Reset mid-operation discards every in-flight result. No partial result is emitted afterward.
- Latency: operands accepted at edge N (in_valid && in_ready) appear with out_valid=1 after edge N+STAGES−1+1. That is STAGES cycles, with no stall.
- Throughput: one result per cycle while out_ready is held at 1.
- Stall: with out_ready=0 and all stages full, in_ready=0 and every register holds. A full pipe accepts at most STAGES results before in_ready drops.
- Simultaneous in_valid and drain on a full pipe: accept and drain occur in the same cycle with no lost or duplicated entry.
- Results leave strictly in acceptance order.
- While out_valid=1 and out_ready=0, outputs must remain stable.

## Test plan
- WIDTH=16, STAGES=1: a=0x7FFF, b=0x0001, sub=0, cin=0 -> after 1 cycle, sum=0x8000, cout=0, overflow=1, zero=0.
- WIDTH=16, STAGES=2: a=0x1234, b=0x1234, sub=1, cin=0 -> after 2 cycles, sum=0x0000, zero=1, cout=1, overflow=0.
- WIDTH=16, STAGES=4: a=0x00FF, b=0x0001, sub=0, cin=1 -> sum=0x0101. Also a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. This checks carry crossing every stage boundary.
- WIDTH=32, STAGES=4: stream 100 back-to-back random operands with out_ready=1 -> one result per cycle after 4-cycle fill, matching a reference model in order.
- STAGES=2: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, outputs stable. Then toggle out_ready -> no loss or duplication.
- Assert rst with 2 entries in flight -> out_valid=0 and all outputs 0 immediately. The next accepted operation completes normally after STAGES cycles.
